// File: rtl/core_bus_arb.sv
// Two-master (instruction fetch, load/store) to one-slave pipelined Wishbone arbiter
// with registered grant, LS priority, beat-boundary handoff and a stall watchdog.
module core_bus_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_cyc,
  input  logic                if_stb,
  input  logic                if_we,
  input  logic [ADDR_W-1:0]   if_adr,
  input  logic [DATA_W/8-1:0] if_sel,
  input  logic [DATA_W-1:0]   if_dat_mo,
  output logic [DATA_W-1:0]   if_dat_so,
  output logic                if_ack,
  output logic                if_err,

  input  logic                ls_cyc,
  input  logic                ls_stb,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_adr,
  input  logic [DATA_W/8-1:0] ls_sel,
  input  logic [DATA_W-1:0]   ls_dat_mo,
  output logic [DATA_W-1:0]   ls_dat_so,
  output logic                ls_ack,
  output logic                ls_err,

  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [DATA_W-1:0]   s_dat_mo,
  input  logic [DATA_W-1:0]   s_dat_so,
  input  logic                s_ack,
  input  logic                s_err,

  output logic [1:0]          gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IF = 2'b01,
    GNT_LS = 2'b10
  } state_t;

  localparam bit WD_ON = (TIMEOUT > 0);
  localparam int CNT_W = WD_ON ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = WD_ON ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic granted_stb;
  logic term;
  logic stall;
  logic abort;

  // Strobe of whichever master owns the bus, kept separate from the output mux
  // so the watchdog does not depend on the routed termination signals.
  always_comb begin
    granted_stb = 1'b0;
    case (state_reg)
      GNT_IF:  granted_stb = if_stb;
      GNT_LS:  granted_stb = ls_stb;
      default: granted_stb = 1'b0;
    endcase
  end

  assign term  = s_ack | s_err;
  assign stall = (state_reg != IDLE) && granted_stb && !term;
  assign abort = WD_ON && stall && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (ls_cyc)      state_reg <= GNT_LS;
          else if (if_cyc) state_reg <= GNT_IF;
        end
        GNT_IF: begin
          if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (!if_cyc) begin
            state_reg <= ls_cyc ? GNT_LS : IDLE;
            cnt_reg   <= '0;
          end else if (ls_cyc && term) begin
            // Hand over only on a beat boundary so an IF beat is never cut.
            state_reg <= GNT_LS;
            cnt_reg   <= '0;
          end else if (term) begin
            cnt_reg <= '0;
          end else if (stall) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        GNT_LS: begin
          if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (!ls_cyc) begin
            state_reg <= if_cyc ? GNT_IF : IDLE;
            cnt_reg   <= '0;
          end else if (term) begin
            cnt_reg <= '0;
          end else if (stall) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Bus routing follows the registered grant only; IDLE parks everything at zero.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_sel     = '0;
    s_dat_mo  = '0;
    if_dat_so = '0;
    if_ack    = 1'b0;
    if_err    = 1'b0;
    ls_dat_so = '0;
    ls_ack    = 1'b0;
    ls_err    = 1'b0;
    case (state_reg)
      GNT_IF: begin
        s_cyc     = if_cyc;
        s_stb     = if_stb;
        s_we      = if_we;
        s_adr     = if_adr;
        s_sel     = if_sel;
        s_dat_mo  = if_dat_mo;
        if_dat_so = s_dat_so;
        if_ack    = s_ack & ~abort;
        if_err    = s_err | abort;
      end
      GNT_LS: begin
        s_cyc     = ls_cyc;
        s_stb     = ls_stb;
        s_we      = ls_we;
        s_adr     = ls_adr;
        s_sel     = ls_sel;
        s_dat_mo  = ls_dat_mo;
        ls_dat_so = s_dat_so;
        ls_ack    = s_ack & ~abort;
        ls_err    = s_err | abort;
      end
      default: ;
    endcase
  end

  assign gnt = state_reg;

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed bench for core_bus_arb: reset, IF streaming, LS priority and atomic
// bursts, watchdog abort (TIMEOUT=4) and asynchronous reset mid-beat.
module tb_core_bus_arb;

  logic        clk;
  logic        rst;
  logic        if_cyc, if_stb, if_we;
  logic [31:0] if_adr;
  logic [3:0]  if_sel;
  logic [31:0] if_dat_mo, if_dat_so;
  logic        if_ack, if_err;
  logic        ls_cyc, ls_stb, ls_we;
  logic [31:0] ls_adr;
  logic [3:0]  ls_sel;
  logic [31:0] ls_dat_mo, ls_dat_so;
  logic        ls_ack, ls_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_mo, s_dat_so;
  logic        s_ack, s_err;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;

  core_bus_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_cyc(if_cyc), .if_stb(if_stb), .if_we(if_we), .if_adr(if_adr),
    .if_sel(if_sel), .if_dat_mo(if_dat_mo), .if_dat_so(if_dat_so),
    .if_ack(if_ack), .if_err(if_err),
    .ls_cyc(ls_cyc), .ls_stb(ls_stb), .ls_we(ls_we), .ls_adr(ls_adr),
    .ls_sel(ls_sel), .ls_dat_mo(ls_dat_mo), .ls_dat_so(ls_dat_so),
    .ls_ack(ls_ack), .ls_err(ls_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_mo(s_dat_mo), .s_dat_so(s_dat_so),
    .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    if_cyc = 1'b1; if_stb = 1'b1; if_we = 1'b0; if_adr = 32'h1000;
    if_sel = 4'hF; if_dat_mo = 32'h0;
    ls_cyc = 1'b1; ls_stb = 1'b1; ls_we = 1'b0; ls_adr = 32'h100;
    ls_sel = 4'hF; ls_dat_mo = 32'h0;
    s_dat_so = 32'h0; s_ack = 1'b1; s_err = 1'b1;

    // Reset held with both masters requesting and a stray slave termination.
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_adr", s_adr, 32'h0);
    chk("rst_if_ack", if_ack, 1'b0);
    chk("rst_ls_err", ls_err, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_gnt", gnt, 2'b00);
    chk("rst_hold_s_stb", s_stb, 1'b0);

    @(negedge clk); rst = 1'b1; s_ack = 1'b0; s_err = 1'b0;
    #1;
    chk("rel_gnt", gnt, 2'b00);
    chk("rel_s_cyc", s_cyc, 1'b0);
    @(negedge clk); #1;
    chk("ls_win_gnt", gnt, 2'b10);
    chk("ls_win_s_adr", s_adr, 32'h100);
    chk("ls_win_s_cyc", s_cyc, 1'b1);

    // LS releases; IF streams three acked beats.
    @(negedge clk); ls_cyc = 1'b0; ls_stb = 1'b0; if_adr = 32'h0;
    #1;
    chk("ls_rel_gnt", gnt, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_adr = 32'(i * 4); s_ack = 1'b1; s_dat_so = 32'(32'h11 * (i + 1));
      #1;
      chk("if_str_gnt", gnt, 2'b01);
      chk("if_str_adr", s_adr, 32'(i * 4));
      chk("if_str_ack", if_ack, 1'b1);
      chk("if_str_dat", if_dat_so, 32'(32'h11 * (i + 1)));
      chk("if_str_ls_ack", ls_ack, 1'b0);
      chk("if_str_ls_dat", ls_dat_so, 32'h0);
    end

    // LS requests mid-stall: IF keeps the bus until its beat terminates.
    @(negedge clk);
    if_adr = 32'hC; s_ack = 1'b0;
    ls_cyc = 1'b1; ls_stb = 1'b1; ls_we = 1'b1; ls_adr = 32'h200;
    ls_sel = 4'b0011; ls_dat_mo = 32'hDEADBEEF;
    #1;
    chk("if_hold_gnt", gnt, 2'b01);
    chk("if_hold_ack", if_ack, 1'b0);
    @(negedge clk); s_ack = 1'b1; s_dat_so = 32'h44;
    #1;
    chk("if_last_gnt", gnt, 2'b01);
    chk("if_last_ack", if_ack, 1'b1);

    // Three-beat LS sequence: write then two reads, IF starved.
    @(negedge clk); s_ack = 1'b1;
    #1;
    chk("ls_b0_gnt", gnt, 2'b10);
    chk("ls_b0_adr", s_adr, 32'h200);
    chk("ls_b0_we", s_we, 1'b1);
    chk("ls_b0_sel", s_sel, 4'b0011);
    chk("ls_b0_dat", s_dat_mo, 32'hDEADBEEF);
    chk("ls_b0_ack", ls_ack, 1'b1);
    chk("ls_b0_if_ack", if_ack, 1'b0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      ls_we = 1'b0; ls_adr = 32'(32'h200 + i * 4); ls_sel = 4'hF;
      s_dat_so = (i == 1) ? 32'hA5 : 32'h5A;
      #1;
      chk("ls_rd_gnt", gnt, 2'b10);
      chk("ls_rd_we", s_we, 1'b0);
      chk("ls_rd_sel", s_sel, 4'hF);
      chk("ls_rd_dat", ls_dat_so, (i == 1) ? 32'hA5 : 32'h5A);
      chk("ls_rd_if_ack", if_ack, 1'b0);
      chk("ls_rd_if_dat", if_dat_so, 32'h0);
    end
    @(negedge clk); ls_cyc = 1'b0; ls_stb = 1'b0; s_ack = 1'b0;
    #1;
    chk("ls_end_gnt", gnt, 2'b10);
    chk("ls_end_if_ack", if_ack, 1'b0);
    @(negedge clk); s_ack = 1'b1; s_dat_so = 32'h55;
    #1;
    chk("handoff_gnt", gnt, 2'b01);
    chk("handoff_adr", s_adr, 32'hC);
    chk("handoff_ack", if_ack, 1'b1);
    chk("handoff_dat", if_dat_so, 32'h55);

    // Simultaneous ack and err pass straight through.
    @(negedge clk); if_adr = 32'h10; s_ack = 1'b1; s_err = 1'b1;
    #1;
    chk("ackerr_ack", if_ack, 1'b1);
    chk("ackerr_err", if_err, 1'b1);
    chk("ackerr_ls_err", ls_err, 1'b0);

    // Slave goes silent: watchdog fires in the 4th stalled cycle.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); if_adr = 32'h40; s_ack = 1'b0; s_err = 1'b0;
      #1;
      chk("wd_gnt", gnt, 2'b01);
      chk("wd_err", if_err, (i == 4));
      chk("wd_ack", if_ack, 1'b0);
    end
    @(negedge clk); #1;
    chk("wd_idle_gnt", gnt, 2'b00);
    chk("wd_idle_s_cyc", s_cyc, 1'b0);
    chk("wd_idle_err", if_err, 1'b0);
    @(negedge clk); s_ack = 1'b1;
    #1;
    chk("wd_regrant_gnt", gnt, 2'b01);
    chk("wd_regrant_ack", if_ack, 1'b1);
    chk("wd_regrant_err", if_err, 1'b0);

    // Asynchronous reset in the middle of an LS beat.
    @(negedge clk);
    s_ack = 1'b0; if_cyc = 1'b0; if_stb = 1'b0;
    ls_cyc = 1'b1; ls_stb = 1'b1; ls_adr = 32'h300;
    #1;
    chk("pre_ls_gnt", gnt, 2'b01);
    @(negedge clk); #1;
    chk("mid_ls_gnt", gnt, 2'b10);
    chk("mid_ls_s_cyc", s_cyc, 1'b1);
    chk("mid_ls_adr", s_adr, 32'h300);
    #1; rst = 1'b0; s_ack = 1'b1;
    #1;
    chk("arst_s_cyc", s_cyc, 1'b0);
    chk("arst_gnt", gnt, 2'b00);
    chk("arst_ls_ack", ls_ack, 1'b0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("arst_rel_gnt", gnt, 2'b00);
    chk("arst_rel_ls_ack", ls_ack, 1'b0);
    @(negedge clk); ls_cyc = 1'b0; ls_stb = 1'b0; s_ack = 1'b0;
    #1;
    chk("arst_regrant_gnt", gnt, 2'b10);
    @(negedge clk); #1;
    chk("final_idle_gnt", gnt, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_bus_arb.md
Name: core_bus_arb

Overview:
- Two-master, one-slave arbiter for the core's single pipelined Wishbone memory port.
- Shares that port between the instruction-fetch stage (IF master) and the load/store stage (LS master).
- Sequences the grant between them and enforces a bus-timeout watchdog.
- A master that is not granted sees ack=0, so it stalls naturally and holds its address.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; select width is DATA_W/8.
- TIMEOUT, 255, number of stalled cycles (no ack/err) before the arbiter aborts the transfer; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_cyc, if_stb, if_we  in  1  IF master control
- if_adr  in  ADDR_W  IF address
- if_sel  in  DATA_W/8  IF byte select
- if_dat_mo  in  DATA_W  IF write data
- if_dat_so  out  DATA_W  read data to IF
- if_ack, if_err  out  1  IF termination
- ls_cyc, ls_stb, ls_we  in  1  LS master control
- ls_adr  in  ADDR_W  LS address
- ls_sel  in  DATA_W/8  LS byte select
- ls_dat_mo  in  DATA_W  LS write data
- ls_dat_so  out  DATA_W  read data to LS
- ls_ack, ls_err  out  1  LS termination
- s_cyc, s_stb, s_we  out  1  slave control
- s_adr  out  ADDR_W  slave address
- s_sel  out  DATA_W/8  slave byte select
- s_dat_mo  out  DATA_W  slave write data
- s_dat_so  in  DATA_W  slave read data
- s_ack, s_err  in  1  slave termination
- gnt  out  2  grant state: 00 IDLE, 01 IF, 10 LS

Behaviour:
- State register: IDLE, GNT_IF, GNT_LS; stall counter cnt is $clog2(TIMEOUT+1) bits.
- Reset (rst=0, async): state=IDLE, cnt=0.
- Outputs during and after reset until the first grant: all s_* = 0, all master ack/err = 0, gnt = 00.
- Routing is purely combinational from the current state:
  - In a grant state, the granted master's cyc/stb/we/adr/sel/dat_mo drive s_*.
  - The granted master receives s_ack, s_err and s_dat_so.
  - The non-granted master gets ack=0, err=0, dat_so=0.
- In IDLE, every s_* output is 0.
- Grant latency: a request seen in cycle N takes effect in cycle N+1 (registered state). No combinational path from cyc to grant.
- Transitions out of IDLE:
  - ls_cyc=1 -> GNT_LS (LS has priority).
  - else if_cyc=1 -> GNT_IF.
  - else stay in IDLE.
- Transitions out of GNT_IF:
  - if_cyc=0 -> ls_cyc ? GNT_LS : IDLE.
  - ls_cyc=1 and (s_ack|s_err) this cycle -> GNT_LS. The IF beat completes first and is never cut mid-transfer.
  - Otherwise hold.
- Transitions out of GNT_LS:
  - Hold while ls_cyc=1, so multi-beat and read-modify-write sequences stay atomic.
  - ls_cyc=0 -> if_cyc ? GNT_IF : IDLE (direct handoff, no idle bubble).
- Watchdog (TIMEOUT>0):
  - cnt increments each grant-state cycle with s_stb=1 and s_ack=0 and s_err=0.
  - cnt clears on ack/err, on any state change, and in IDLE.
  - When cnt == TIMEOUT-1 and still no termination, that cycle drives err=1 to the granted master; the next state is IDLE and cnt=0.
  - The abort overrides the ack routing for that cycle only.
- Simultaneous s_ack and s_err: both are passed through; the master treats err as dominant.
- s_ack/s_err arriving while in IDLE are ignored and not forwarded.
- rst asserted mid-transfer: immediate return to IDLE, s_cyc drops asynchronously, and no termination is forwarded.

Test Plan:
- Reset with both cyc high -> gnt=00 and s_cyc=0 during reset; first cycle after release gnt=00; next cycle gnt=10 (LS wins) and s_adr=ls_adr.
- IF streaming alone, adr 0x0,0x4,0x8, slave acks every cycle -> gnt=01 from cycle 1; three if_ack pulses; if_dat_so=s_dat_so; ls_ack=0 throughout.
- IF streaming, ls_cyc rises at cycle 5 with slave ack at cycle 5 -> gnt=10 in cycle 6, s_adr=ls_adr; IF sees no ack until ls_cyc drops, then gnt=01 the next cycle with no idle cycle.
- LS holds cyc for 3 beats (write 0xDEADBEEF, sel=4'b0011, then 2 reads) while if_cyc=1 -> gnt stays 10 for all 3 beats; s_we and s_sel follow ls_*; IF is starved until ls_cyc=0.
- TIMEOUT=4, IF granted, slave never acks -> if_err=1 exactly in the 4th stalled cycle; gnt=00 the next cycle; regrant to IF the cycle after.
- Reset pulsed while gnt=10 mid-beat -> s_cyc=0 asynchronously; ls_ack is not asserted; gnt=00 after release.
